// File: rtl/coax_rx.sv
// coax_rx -- Manchester coax line receiver.
//
// Recovers bit timing from the raw coax line, recognises the start sequence
// (a run of ones, a low code violation, a one, a high code violation),
// deframes 12-bit-cell words (sync 1, ten data bits MSB first, even parity),
// and presents each word with a single-cycle strobe. A zero in the sync
// position followed by a high code violation ends the message.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   rx          raw coax line level (asynchronous to clk)
//   active      high while a message is being received
//   data        last received word, held between strobes
//   strobe      one-cycle pulse, data valid in the same cycle
//   error       one-cycle pulse on any receive error
//   error_code  1 = parity, 2 = start sequence, 3 = framing / lost mid-bit
module coax_rx #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       active,
    output logic [9:0] data,
    output logic       strobe,
    output logic       error,
    output logic [1:0] error_code
);

    localparam int Q  = CLOCKS_PER_BIT / 4;
    localparam int TW = $clog2(5 * Q + 2);
    localparam int LW = $clog2(CLOCKS_PER_BIT);

    // The timer holds the number of clocks elapsed since the last real or
    // virtual mid-bit, the cycle that detected it counting as zero. A
    // violation stands for a virtual mid-bit Q clocks earlier, so the timer
    // resumes at Q+1 and the next real transition lands mid-window.
    localparam logic [TW-1:0] T_MID_LO  = TW'(3 * Q);
    localparam logic [TW-1:0] T_MID_HI  = TW'(5 * Q);
    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [TW-1:0] T_AFTER_V = TW'(Q + 1);
    localparam logic [LW-1:0] LOW_LAST  = LW'(CLOCKS_PER_BIT - 1);

    localparam logic [1:0] ERR_PARITY = 2'd1;
    localparam logic [1:0] ERR_START  = 2'd2;
    localparam logic [1:0] ERR_FRAME  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARM        = 3'd1,
        ST_START_ONES = 3'd2,
        ST_START_ONE  = 3'd3,
        ST_START_V1   = 3'd4,
        ST_DATA       = 3'd5,
        ST_PARITY     = 3'd6,
        ST_END        = 3'd7
    } state_t;

    // True when sync, data and parity together hold an even number of ones.
    function automatic logic parity_even_ok(input logic [11:0] word);
        parity_even_ok = ~(^word);
    endfunction

    logic          sync1_r;
    logic          rx_sync_r;
    logic          rx_prev_r;
    logic [TW-1:0] t_r;
    logic [LW-1:0] low_cnt_r;
    state_t        state_r;
    logic [2:0]    ones_r;
    logic [3:0]    bit_cnt_r;
    logic [9:0]    shift_r;
    logic          active_r;
    logic [9:0]    data_r;
    logic          strobe_r;
    logic          error_r;
    logic [1:0]    error_code_r;

    logic edge_s;
    logic bit_evt_s;
    logic viol_evt_s;
    logic any_evt_s;
    logic arm_rise_s;

    // Two-stage synchronizer plus previous-level register for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r   <= 1'b0;
            rx_sync_r <= 1'b0;
            rx_prev_r <= 1'b0;
        end else begin
            sync1_r   <= rx;
            rx_sync_r <= sync1_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Line event decode: mid-bit transitions and code violations
    always_comb begin
        edge_s     = 1'b0;
        bit_evt_s  = 1'b0;
        viol_evt_s = 1'b0;
        any_evt_s  = 1'b0;
        arm_rise_s = 1'b0;
        edge_s = rx_sync_r ^ rx_prev_r;
        if (edge_s && (t_r >= T_MID_LO) && (t_r <= T_MID_HI)) begin
            bit_evt_s = 1'b1;
        end else begin
            bit_evt_s = 1'b0;
        end
        if (!edge_s && (t_r == T_MID_HI)) begin
            viol_evt_s = 1'b1;
        end else begin
            viol_evt_s = 1'b0;
        end
        any_evt_s  = bit_evt_s | viol_evt_s;
        arm_rise_s = (state_r == ST_ARM) && edge_s && rx_sync_r;
    end

    // Bit timer: restarts on mid-bit transitions, re-centres after violations
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_r <= {TW{1'b0}};
        end else if (bit_evt_s || arm_rise_s) begin
            t_r <= T_ONE;
        end else if (viol_evt_s) begin
            t_r <= T_AFTER_V;
        end else begin
            t_r <= t_r + TW'(1);
        end
    end

    // Receive FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            low_cnt_r    <= {LW{1'b0}};
            ones_r       <= 3'd0;
            bit_cnt_r    <= 4'd0;
            shift_r      <= 10'd0;
            active_r     <= 1'b0;
            data_r       <= 10'd0;
            strobe_r     <= 1'b0;
            error_r      <= 1'b0;
            error_code_r <= 2'd0;
        end else begin
            strobe_r <= 1'b0;
            error_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Arm only after a full bit cell of quiet-low line
                    if (rx_sync_r) begin
                        low_cnt_r <= {LW{1'b0}};
                    end else if (low_cnt_r == LOW_LAST) begin
                        low_cnt_r <= {LW{1'b0}};
                        state_r   <= ST_ARM;
                    end else begin
                        low_cnt_r <= low_cnt_r + LW'(1);
                    end
                end
                ST_ARM: begin
                    if (arm_rise_s) begin
                        ones_r   <= 3'd1;
                        active_r <= 1'b1;
                        state_r  <= ST_START_ONES;
                    end else begin
                        state_r <= ST_ARM;
                    end
                end
                ST_START_ONES: begin
                    if (bit_evt_s && rx_sync_r) begin
                        if (ones_r != 3'd7) begin
                            ones_r <= ones_r + 3'd1;
                        end else begin
                            ones_r <= ones_r;
                        end
                    end else if (viol_evt_s && !rx_sync_r && (ones_r >= 3'd4)) begin
                        state_r <= ST_START_ONE;
                    end else if (any_evt_s) begin
                        state_r      <= ST_IDLE;
                        active_r     <= 1'b0;
                        error_r      <= 1'b1;
                        error_code_r <= ERR_START;
                    end else begin
                        state_r <= ST_START_ONES;
                    end
                end
                ST_START_ONE: begin
                    if (bit_evt_s && rx_sync_r) begin
                        state_r <= ST_START_V1;
                    end else if (any_evt_s) begin
                        state_r      <= ST_IDLE;
                        active_r     <= 1'b0;
                        error_r      <= 1'b1;
                        error_code_r <= ERR_START;
                    end else begin
                        state_r <= ST_START_ONE;
                    end
                end
                ST_START_V1: begin
                    if (viol_evt_s && rx_sync_r) begin
                        bit_cnt_r <= 4'd0;
                        state_r   <= ST_DATA;
                    end else if (any_evt_s) begin
                        state_r      <= ST_IDLE;
                        active_r     <= 1'b0;
                        error_r      <= 1'b1;
                        error_code_r <= ERR_START;
                    end else begin
                        state_r <= ST_START_V1;
                    end
                end
                ST_DATA: begin
                    // bit_cnt 0 is the sync position; 1..10 are data bits
                    if (bit_evt_s) begin
                        if (bit_cnt_r == 4'd0) begin
                            if (rx_sync_r) begin
                                bit_cnt_r <= 4'd1;
                            end else begin
                                state_r <= ST_END;
                            end
                        end else begin
                            shift_r <= {shift_r[8:0], rx_sync_r};
                            if (bit_cnt_r == 4'd10) begin
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_PARITY;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end else if (viol_evt_s) begin
                        state_r      <= ST_IDLE;
                        active_r     <= 1'b0;
                        error_r      <= 1'b1;
                        error_code_r <= ERR_FRAME;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_PARITY: begin
                    // A parity error still delivers the word and keeps receiving
                    if (bit_evt_s) begin
                        data_r    <= shift_r;
                        strobe_r  <= 1'b1;
                        bit_cnt_r <= 4'd0;
                        state_r   <= ST_DATA;
                        if (!parity_even_ok({1'b1, shift_r, rx_sync_r})) begin
                            error_r      <= 1'b1;
                            error_code_r <= ERR_PARITY;
                        end else begin
                            error_r <= 1'b0;
                        end
                    end else if (viol_evt_s) begin
                        state_r      <= ST_IDLE;
                        active_r     <= 1'b0;
                        error_r      <= 1'b1;
                        error_code_r <= ERR_FRAME;
                    end else begin
                        state_r <= ST_PARITY;
                    end
                end
                ST_END: begin
                    if (viol_evt_s && rx_sync_r) begin
                        state_r  <= ST_IDLE;
                        active_r <= 1'b0;
                    end else if (any_evt_s) begin
                        state_r      <= ST_IDLE;
                        active_r     <= 1'b0;
                        error_r      <= 1'b1;
                        error_code_r <= ERR_FRAME;
                    end else begin
                        state_r <= ST_END;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    active_r <= 1'b0;
                end
            endcase
        end
    end

    assign active     = active_r;
    assign data       = data_r;
    assign strobe     = strobe_r;
    assign error      = error_r;
    assign error_code = error_code_r;

endmodule

// File: tb/tb_coax_rx.sv
// tb_coax_rx -- directed self-checking bench for coax_rx (CLOCKS_PER_BIT = 8).
// Drives Manchester messages on rx (changes on falling clk edges), records
// strobes/errors from a negedge monitor and compares against hand-computed
// expectations through one checking task.
module tb_coax_rx;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       active;
    logic [9:0] data;
    logic       strobe;
    logic       error;
    logic [1:0] error_code;

    coax_rx #(.CLOCKS_PER_BIT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .active     (active),
        .data       (data),
        .strobe     (strobe),
        .error      (error),
        .error_code (error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_r = 0;
    // Rising-edge counter used to time-stamp events
    always @(posedge clk) cyc_r <= cyc_r + 1;

    logic [9:0] sd_q[$];
    int         st_q[$];
    logic       se_q[$];
    logic [1:0] ec_q[$];
    int         pe_q[$];
    int         act_cnt = 0;

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (strobe) begin
            sd_q.push_back(data);
            st_q.push_back(cyc_r);
            se_q.push_back(error);
        end
        if (error) ec_q.push_back(error_code);
        if (active) act_cnt++;
    end

    int check_cnt = 0;
    int pass_cnt  = 0;
    int bidx      = 0;
    bit jit_en    = 1'b0;
    int s_base, e_base, p_base, a_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic hold(input logic lvl, input int n);
        rx = lvl;
        repeat (n) @(negedge clk);
    endtask

    // One Manchester bit cell; j shifts the mid-bit transition
    task automatic send_bit(input logic b, input int j, input bit mark);
        rx = ~b;
        repeat (4 + j) @(negedge clk);
        if (mark) pe_q.push_back(cyc_r);
        rx = b;
        repeat (4 - j) @(negedge clk);
    endtask

    task automatic word_bit(input logic b, input bit mark);
        int j;
        j = jit_en ? ((bidx % 2 == 1) ? 1 : -1) : 0;
        bidx++;
        send_bit(b, j, mark);
    endtask

    task automatic send_start(input int n_ones);
        hold(1'b0, 16);
        for (int i = 0; i < n_ones; i++) send_bit(1'b1, 0, 1'b0);
        hold(1'b0, 8);
        send_bit(1'b1, 0, 1'b0);
        hold(1'b1, 8);
        bidx = 0;
    endtask

    task automatic send_word(input logic [9:0] w, input bit flip);
        logic p;
        p = 1'b1 ^ (^w) ^ flip;
        word_bit(1'b1, 1'b0);
        for (int i = 9; i >= 0; i--) word_bit(w[i], 1'b0);
        word_bit(p, 1'b1);
    endtask

    task automatic send_end();
        word_bit(1'b0, 1'b0);
        hold(1'b1, 8);
        hold(1'b1, 24);
    endtask

    task automatic mark_bases();
        s_base = sd_q.size();
        e_base = ec_q.size();
        p_base = pe_q.size();
        a_base = act_cnt;
    endtask

    task automatic expect_single(input string tag, input logic [9:0] w);
        check({tag, "_nstrobe"}, sd_q.size() - s_base, 1);
        if (sd_q.size() > s_base) begin
            check({tag, "_data"}, sd_q[s_base], w);
            check({tag, "_lat"}, st_q[s_base] - pe_q[p_base], 3);
        end
        check({tag, "_nerr"}, ec_q.size() - e_base, 0);
    endtask

    initial begin
        rx    = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_active", active, 0);
        check("rst_strobe", strobe, 0);
        check("rst_error", error, 0);
        check("rst_data", data, 0);
        check("rst_code", error_code, 0);
        reset = 1'b1;

        // single word, correct parity
        mark_bases();
        send_start(5);
        send_word(10'h2A5, 1'b0);
        send_end();
        expect_single("t1", 10'h2A5);
        if (se_q.size() > s_base) check("t1_strb_err", se_q[s_base], 0);
        check("t1_active_seen", act_cnt > a_base, 1);
        check("t1_active_end", active, 0);

        // three jittered words back-to-back, long start run (ones saturate)
        jit_en = 1'b1;
        mark_bases();
        send_start(9);
        send_word(10'h000, 1'b0);
        send_word(10'h3FF, 1'b0);
        send_word(10'h155, 1'b0);
        send_end();
        jit_en = 1'b0;
        check("t2_nstrobe", sd_q.size() - s_base, 3);
        check("t2_nerr", ec_q.size() - e_base, 0);
        if (sd_q.size() >= s_base + 3) begin
            check("t2_d0", sd_q[s_base], 10'h000);
            check("t2_d1", sd_q[s_base + 1], 10'h3FF);
            check("t2_d2", sd_q[s_base + 2], 10'h155);
            check("t2_gap01", st_q[s_base + 1] - st_q[s_base], 96);
            check("t2_gap12", st_q[s_base + 2] - st_q[s_base + 1], 96);
            for (int i = 0; i < 3; i++)
                check("t2_lat", st_q[s_base + i] - pe_q[p_base + i], 3);
        end

        // parity error on first word, second word still received
        mark_bases();
        send_start(5);
        send_word(10'h2A5, 1'b1);
        send_word(10'h0F0, 1'b0);
        send_end();
        check("t3_nstrobe", sd_q.size() - s_base, 2);
        check("t3_nerr", ec_q.size() - e_base, 1);
        if (sd_q.size() >= s_base + 2) begin
            check("t3_d0", sd_q[s_base], 10'h2A5);
            check("t3_e0", se_q[s_base], 1);
            check("t3_d1", sd_q[s_base + 1], 10'h0F0);
            check("t3_e1", se_q[s_base + 1], 0);
        end
        if (ec_q.size() > e_base) check("t3_code", ec_q[e_base], 1);

        // start sequence with only two ones
        mark_bases();
        hold(1'b0, 16);
        send_bit(1'b1, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        hold(1'b0, 24);
        check("t4_nerr", ec_q.size() - e_base, 1);
        if (ec_q.size() > e_base) check("t4_code", ec_q[e_base], 2);
        check("t4_nstrobe", sd_q.size() - s_base, 0);
        check("t4_active", active, 0);
        mark_bases();
        send_start(5);
        send_word(10'h0F0, 1'b0);
        send_end();
        expect_single("t4b", 10'h0F0);

        // line stuck high after five data bits
        mark_bases();
        send_start(5);
        word_bit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) word_bit(i[0] ? 1'b0 : 1'b1, 1'b0);
        hold(1'b1, 24);
        check("t5_nerr", ec_q.size() - e_base, 1);
        if (ec_q.size() > e_base) check("t5_code", ec_q[e_base], 3);
        check("t5_nstrobe", sd_q.size() - s_base, 0);
        check("t5_active", active, 0);
        mark_bases();
        send_start(5);
        send_word(10'h155, 1'b0);
        send_end();
        expect_single("t5b", 10'h155);

        // reset pulsed mid-word
        send_start(5);
        word_bit(1'b1, 1'b0);
        word_bit(1'b1, 1'b0);
        word_bit(1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("t6_active", active, 0);
        check("t6_strobe", strobe, 0);
        check("t6_error", error, 0);
        check("t6_data", data, 0);
        check("t6_code", error_code, 0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mark_bases();
        hold(1'b1, 20);
        check("t6_quiet_strobe", sd_q.size() - s_base, 0);
        check("t6_quiet_err", ec_q.size() - e_base, 0);
        check("t6_quiet_active", act_cnt - a_base, 0);
        mark_bases();
        send_start(5);
        send_word(10'h3FF, 1'b0);
        send_end();
        expect_single("t6b", 10'h3FF);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
